mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_seq_pkg.sv | 67 ++++++
 rtl/seq_hold_timer.sv | 26 ++
 rtl/mult_sequencer.sv | 112 +++++++++++
 tb/tb_mult_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and opcode constants for the multiply opcode sequencer.
// Opcodes are the 12-bit control words consumed by the control datapath.
package mult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITER_SHIFT,
        NEG,
        ITER_BODY,
        DONE
    } state_t;

    localparam logic [11:0] OP_IDLE        = 12'b000000001001;
    localparam logic [11:0] OP_LD_XB       = 12'b000000001011;
    localparam logic [11:0] OP_LD_YC       = 12'b000000001100;
    localparam logic [11:0] OP_AND_B_LSBC  = 12'b001000000101;
    localparam logic [11:0] OP_SHL_B       = 12'b001000010011;
    localparam logic [11:0] OP_SHR_C       = 12'b000000101010;
    localparam logic [11:0] OP_BO_B        = 12'b100001001011;
    localparam logic [11:0] OP_NEG_B       = 12'b001000011000;
    localparam logic [11:0] OP_AO_A        = 12'b100000001001;
    localparam logic [11:0] OP_AND_B_LSBCO = 12'b001110000101;
    localparam logic [11:0] OP_AO_C        = 12'b010000101100;
    localparam logic [11:0] OP_ADD         = 12'b000000000000;
    localparam logic [11:0] OP_CO_C        = 12'b010010001100;

    function automatic logic [2:0] last_step(state_t s);
        logic [2:0] n;
        n = 3'd0;
        case (s)
            PRE:        n = 3'd2;
            ITER_SHIFT: n = 3'd1;
            NEG:        n = 3'd1;
            ITER_BODY:  n = 3'd5;
            default:    n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [11:0] step_op(state_t s, logic [2:0] k);
        logic [11:0] op;
        op = OP_IDLE;
        case (s)
            PRE: begin
                if (k == 3'd0)      op = OP_LD_XB;
                else if (k == 3'd1) op = OP_LD_YC;
                else                op = OP_AND_B_LSBC;
            end
            ITER_SHIFT: op = (k == 3'd0) ? OP_SHL_B : OP_SHR_C;
            NEG:        op = (k == 3'd0) ? OP_BO_B : OP_NEG_B;
            ITER_BODY: begin
                case (k)
                    3'd0:    op = OP_AO_A;
                    3'd1:    op = OP_BO_B;
                    3'd2:    op = OP_AND_B_LSBCO;
                    3'd3:    op = OP_AO_C;
                    3'd4:    op = OP_ADD;
                    default: op = OP_CO_C;
                endcase
            end
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_hold_timer.sv
// Step hold timer: strobes step_end in the last of HOLD cycles while run
// is high; idles at zero otherwise.
module seq_hold_timer #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic step_end
);

    logic [3:0] cnt;

    assign step_end = run && (cnt == 4'(HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (!run || step_end) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multiply opcode sequencer: emits the preamble, per-iteration shift and
// body steps, and an optional sign step, each held for HOLD cycles.
module mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter int ITER = 5,
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        c_msb,
    input  logic [15:0] aout,
    output logic [11:0] opcode,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam int IW = ($clog2(ITER) > 3) ? $clog2(ITER) : 3;

    state_t        state;
    logic [2:0]    step;
    logic [IW-1:0] idx;
    logic          step_end;
    logic          last;

    assign last = (idx == IW'(ITER - 1));

    seq_hold_timer #(.HOLD(HOLD)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (busy),
        .step_end (step_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= 3'd0;
            idx     <= '0;
            opcode  <= OP_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 16'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= PRE;
                        step   <= 3'd0;
                        busy   <= 1'b1;
                        opcode <= OP_LD_XB;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (step_end) begin
                        // Result is valid on aout at the end of the last ADD
                        if (state == ITER_BODY && step == 3'd4 && last)
                            product <= aout;
                        if (step != last_step(state)) begin
                            step   <= step + 3'd1;
                            opcode <= step_op(state, step + 3'd1);
                        end else begin
                            step <= 3'd0;
                            unique case (state)
                                PRE: begin
                                    state  <= ITER_SHIFT;
                                    opcode <= OP_SHL_B;
                                end
                                ITER_SHIFT: begin
                                    if (c_msb && last) begin
                                        state  <= NEG;
                                        opcode <= OP_BO_B;
                                    end else begin
                                        state  <= ITER_BODY;
                                        opcode <= OP_AO_A;
                                    end
                                end
                                NEG: begin
                                    state  <= ITER_BODY;
                                    opcode <= OP_AO_A;
                                end
                                ITER_BODY: begin
                                    if (!last) begin
                                        idx    <= idx + IW'(1);
                                        state  <= ITER_SHIFT;
                                        opcode <= OP_SHL_B;
                                    end else begin
                                        idx    <= '0;
                                        state  <= DONE;
                                        busy   <= 1'b0;
                                        done   <= 1'b1;
                                        opcode <= OP_IDLE;
                                    end
                                end
                                default: begin
                                    state  <= IDLE;
                                    busy   <= 1'b0;
                                    opcode <= OP_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer with a behavioural control-datapath model
// answering the opcode stream on aout / c_msb.
module tb_mult_sequencer;
    import mult_seq_pkg::*;

    localparam int ITER = 5;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        c_msb;
    logic [15:0] aout;
    logic [11:0] opcode;
    logic        busy;
    logic        done;
    logic [15:0] product;

    always #5 clk = ~clk;

    mult_sequencer #(.ITER(ITER), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .c_msb   (c_msb),
        .aout    (aout),
        .opcode  (opcode),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    int passed = 0;
    int total = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Control model: C rotates right so Cout[15] is the current Y bit;
    // ADD accumulates X<<i, negated once the sign step has run.
    logic [15:0] x = 16'd0;
    logic [15:0] y = 16'd0;
    logic        tie0 = 1'b0;
    logic [15:0] ma = 16'd0;
    int          it = 0;
    logic        mcur = 1'b0;
    logic        mneg = 1'b0;
    logic [11:0] last_op = OP_IDLE;

    assign aout  = ma;
    assign c_msb = tie0 ? 1'b0 : mcur;

    always @(negedge clk) begin
        if (opcode != last_op) begin
            case (opcode)
                OP_LD_XB: begin ma = 16'd0; it = 0; mneg = 1'b0; mcur = 1'b0; end
                OP_SHR_C: begin mcur = y[it]; it++; end
                OP_NEG_B: mneg = 1'b1;
                OP_ADD: begin
                    if (mcur)
                        ma = mneg ? ma - 16'(x << (it - 1))
                                  : ma + 16'(x << (it - 1));
                end
                default: ;
            endcase
            last_op = opcode;
        end
    end

    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          trace_n = 0;
    logic [11:0] tr_op [64];
    int          tr_len [64];

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (busy) begin
            if (trace_n > 0 && opcode == tr_op[trace_n-1]) begin
                tr_len[trace_n-1]++;
            end else if (trace_n < 64) begin
                tr_op[trace_n] = opcode;
                tr_len[trace_n] = 1;
                trace_n++;
            end
        end
    end

    logic [11:0] exp_op [64];
    int          exp_n = 0;

    task automatic build_exp(input logic neg);
        exp_n = 0;
        exp_op[exp_n++] = OP_LD_XB;
        exp_op[exp_n++] = OP_LD_YC;
        exp_op[exp_n++] = OP_AND_B_LSBC;
        for (int i = 0; i < ITER; i++) begin
            exp_op[exp_n++] = OP_SHL_B;
            exp_op[exp_n++] = OP_SHR_C;
            if (neg && i == ITER - 1) begin
                exp_op[exp_n++] = OP_BO_B;
                exp_op[exp_n++] = OP_NEG_B;
            end
            exp_op[exp_n++] = OP_AO_A;
            exp_op[exp_n++] = OP_BO_B;
            exp_op[exp_n++] = OP_AND_B_LSBCO;
            exp_op[exp_n++] = OP_AO_C;
            exp_op[exp_n++] = OP_ADD;
            exp_op[exp_n++] = OP_CO_C;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        tie0;
        logic        neg;
        logic [15:0] prod;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int          bad;
        int          mm;
        logic        seen;
        logic [15:0] prev;
        tick();
        x = v.x;
        y = v.y;
        tie0 = v.tie0;
        busy_cnt = 0;
        done_cnt = 0;
        trace_n = 0;
        prev = product;
        build_exp(v.neg);
        bad = 0;
        seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
            else if (trace_n < exp_n && product !== prev) bad++;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        tick();
        tick();
        mm = 0;
        for (int i = 0; i < exp_n; i++)
            if (i >= trace_n || tr_op[i] !== exp_op[i] || tr_len[i] != HOLD)
                mm++;
        check({tag, " product"}, 32'(product), 32'(v.prod));
        check({tag, " busy_cycles"}, 32'(busy_cnt),
              32'(HOLD * (3 + 8 * ITER + 2 * int'(v.neg))));
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " product_hold"}, 32'(bad), 32'd0);
        check({tag, " step_count"}, 32'(trace_n), 32'(exp_n));
        check({tag, " trace_errs"}, 32'(mm), 32'd0);
        tie0 = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        logic seen;

        // 5-bit two's-complement multiplier; bit 4 set selects the sign step
        vecs[0] = '{16'd10,   16'd3,      1'b0, 1'b0, 16'h001E};
        vecs[1] = '{16'd10,   16'hFFF1,   1'b0, 1'b1, 16'hFF6A};
        vecs[2] = '{16'd7,    16'd5,      1'b0, 1'b0, 16'h0023};
        vecs[3] = '{16'hFFFD, 16'hFFFF,   1'b0, 1'b1, 16'h0003};
        vecs[4] = '{16'd100,  16'd0,      1'b0, 1'b0, 16'h0000};
        vecs[5] = '{16'd1,    16'hFFF0,   1'b0, 1'b1, 16'hFFF0};
        // c_msb held low: no sign step, top partial product adds positively
        vecs[6] = '{16'd10,   16'hFFF1,   1'b1, 1'b0, 16'h00AA};

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("rst opcode", 32'(opcode), 32'(OP_IDLE));
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst product", 32'(product), 32'd0);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // start held high through a run and its DONE cycle
        tick();
        x = 16'd10;
        y = 16'd3;
        busy_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("b2b first_done", 32'(seen), 32'd1);
        tick();
        check("b2b idle_op", 32'(opcode), 32'(OP_IDLE));
        check("b2b idle_busy", 32'(busy), 32'd0);
        tick();
        check("b2b restart_op", 32'(opcode), 32'(OP_LD_XB));
        check("b2b restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("b2b second_done", 32'(seen), 32'd1);
        repeat (4) tick();
        check("b2b done_pulses", 32'(done_cnt), 32'd2);
        check("b2b busy_cycles", 32'(busy_cnt), 32'(2 * HOLD * (3 + 8 * ITER)));
        check("b2b no_queue", 32'(busy), 32'd0);
        check("b2b product", 32'(product), 32'h001E);

        // reset during the body of iteration 2
        tick();
        x = 16'd7;
        y = 16'd5;
        done_cnt = 0;
        trace_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            if (trace_n >= 25) seen = 1'b1;
            else tick();
        end
        check("abort reached", 32'(seen), 32'd1);
        check("abort at_ao_c", 32'(opcode), 32'(OP_AO_C));
        rst_n = 1'b0;
        tick();
        check("abort opcode", 32'(opcode), 32'(OP_IDLE));
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort product", 32'(product), 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("abort no_done", 32'(done_cnt), 32'd0);
        check("abort idle", 32'(busy), 32'd0);
        run_vec(vecs[0], "after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
